mano_control_sequencer: RTL and testbench
=========================================

// Module: mano_control_sequencer
// PURPOSE
//  Timing/control unit for the Mano basic-computer datapath. Runs the fetch ->
//  decode -> indirect -> execute cycle with a T0..T6 sequence counter, and emits
//  one 17-bit control word per cycle to the datapath (AR, PC, DR, IR, AC, memory).
//  Stalls on slow memory via mem_ready. Halts on HLT or on a memory timeout.
// PARAMETERS
//  WAIT_MAX   15  max stall cycles per memory access before bus_err/halt (1..255)
// PORTS
//  clk        in   1   system clock, rising edge
//  reset      in   1   asynchronous, active-high; clears all state
//  start      in   1   pulse: leave IDLE/HALT and begin fetch at T0
//  opcode     in   3   IR[14:12] from datapath; valid from T2
//  ind_bit    in   1   IR[15]; valid from T2
//  ir_low     in   12  IR[11:0]; register-reference micro-op bits
//  ac_zero    in   1   AC == 0
//  ac_neg     in   1   AC[15]
//  dr_zero    in   1   DR == 0 (checked after DR increment)
//  mem_ready  in   1   memory completes current rd/wr this cycle
//  ctrl_word  out  17  control word, fields below
//  sc_out     out  3   current sequence count T (0..6)
//  busy       out  1   1 in any T state
//  halted     out  1   1 in HALT
//  bus_err    out  1   sticky; set on memory timeout, cleared by reset or start
// BEHAVIOUR
//  ctrl_word: [16:14] bus_sel (0 none,1 AR,2 PC,3 DR,4 AC,5 IR,7 MEM);
//   [13:11] alu_op (0 none,1 AND,2 ADD,3 LD_DR,4 CMA,5 INC,6 CLA);
//   [10] ld_ar [9] ld_pc [8] inc_pc [7] ld_ir [6] ld_dr [5] inc_dr [4] inc_ar
//   [3] ld_ac [2] mem_rd [1] mem_wr [0] ld_i.
//  States: IDLE, T0..T6, HALT. Reset -> IDLE; all outputs 0.
//  IDLE/HALT + start -> T0 next cycle; start ignored while busy.
//  T0: AR<-PC. T1: IR<-M[AR], PC++ (mem). T2: latch D=opcode, I=ind_bit;
//   AR<-IR[11:0], ld_i.
//  T3: D=7: I=0 register-ref executes, back to T0; I=1 (I/O) is NOP -> T0.
//   D!=7: I=1 AR<-M[AR] (mem); I=0 no-op. -> T4.
//  T4/T5/T6 (mem = memory access):
//   AND/ADD: T4 DR<-M[AR] (mem); T5 AC<-AC op DR -> T0.
//   LDA: T4 DR<-M[AR] (mem); T5 AC<-DR -> T0.
//   STA: T4 M[AR]<-AC (mem) -> T0.  BUN: T4 PC<-AR -> T0.
//   BSA: T4 M[AR]<-PC, AR++ (mem); T5 PC<-AR -> T0.
//   ISZ: T4 DR<-M[AR] (mem); T5 DR++; T6 M[AR]<-DR (mem), PC++ if dr_zero -> T0.
//  Register-ref (T3, ir_low one-hot, priority MSB first, one op/instr):
//   [11] CLA, [9] CMA, [5] INC, [4] SPA: PC++ if !ac_neg & !ac_zero,
//   [3] SNA: PC++ if ac_neg, [2] SZA: PC++ if ac_zero, [0] HLT -> HALT.
//   ir_low == 0 or other bits: NOP.
//  Memory stall: in mem states, mem_rd/mem_wr and bus_sel held every cycle;
//   load/inc strobes assert only in the cycle mem_ready=1; state advances then.
//   Wait counter resets on entry to each mem state.
//   WAIT_MAX cycles with no mem_ready -> HALT, bus_err=1, ctrl_word 0.
//  sc_out tracks T index; 0 in IDLE/HALT. ctrl_word is registered with state
//   (Moore): word for state S is valid the whole cycle the FSM is in S.
//  Reset mid-instruction: abort immediately to IDLE; no partial strobes.
//  opcode/ind_bit sampled only in T2; later changes ignored until next T2.
// STRUCTURE
//  Package mano_ctrl_pkg: state enum, opcode constants (AND..ISZ, REG=7),
//   ctrl_word field bit positions, bus_sel/alu_op encodings.
//  Sub-module mano_mem_wait_timer: counter with clear/enable, flags at WAIT_MAX.
//  Top: FSM + registered control-word decode.
// TESTING
//  reset, start, mem_ready=1, ADD (D=1,I=0) -> T0..T5 words exact, AC ld at T5, 6 cycles.
//  I=1 LDA, mem_ready low 3 cycles in T3 -> stall 3, ld_ar only in ready cycle.
//  ISZ, dr_zero=1 at T6 -> mem_wr + inc_pc in T6; dr_zero=0 -> no inc_pc.
//  BSA -> T4 mem_wr+inc_ar, T5 ld_pc, bus_sel=AR; then T0.
//  ir_low=12'h001 at T3 (D=7,I=0) -> HALT; start -> T0 next cycle.
//  mem_ready held 0 in T1, WAIT_MAX=4 -> HALT after 4 cycles, bus_err=1; reset in T4 -> IDLE, outputs 0.

Source files
------------

// File: rtl/mano_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package : mano_ctrl_pkg
// Brief   : Shared types and encodings for the Mano basic-computer sequencer.
// Rev     : 1.0  initial release
// ============================================================================
package mano_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_BUN = 3'd4;
    localparam logic [2:0] OP_BSA = 3'd5;
    localparam logic [2:0] OP_ISZ = 3'd6;
    localparam logic [2:0] OP_REG = 3'd7;

    localparam int CW_W      = 17;
    localparam int CW_LD_AR  = 10;
    localparam int CW_LD_PC  = 9;
    localparam int CW_INC_PC = 8;
    localparam int CW_LD_IR  = 7;
    localparam int CW_LD_DR  = 6;
    localparam int CW_INC_DR = 5;
    localparam int CW_INC_AR = 4;
    localparam int CW_LD_AC  = 3;
    localparam int CW_MEM_RD = 2;
    localparam int CW_MEM_WR = 1;
    localparam int CW_LD_I   = 0;

    // Load/increment strobes: bits 10..3 and 0 (everything but bus, alu, rd, wr)
    localparam logic [CW_W-1:0] CW_STROBE_MASK = 17'h007F9;

    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_AR   = 3'd1;
    localparam logic [2:0] BUS_PC   = 3'd2;
    localparam logic [2:0] BUS_DR   = 3'd3;
    localparam logic [2:0] BUS_AC   = 3'd4;
    localparam logic [2:0] BUS_IR   = 3'd5;
    localparam logic [2:0] BUS_MEM  = 3'd7;

    localparam logic [2:0] ALU_NONE  = 3'd0;
    localparam logic [2:0] ALU_AND   = 3'd1;
    localparam logic [2:0] ALU_ADD   = 3'd2;
    localparam logic [2:0] ALU_LD_DR = 3'd3;
    localparam logic [2:0] ALU_CMA   = 3'd4;
    localparam logic [2:0] ALU_INC   = 3'd5;
    localparam logic [2:0] ALU_CLA   = 3'd6;

    function automatic logic [2:0] sc_of(input state_t s);
        case (s)
            S_T1:    return 3'd1;
            S_T2:    return 3'd2;
            S_T3:    return 3'd3;
            S_T4:    return 3'd4;
            S_T5:    return 3'd5;
            S_T6:    return 3'd6;
            default: return 3'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mano_mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module : mano_mem_wait_timer
// Brief  : Counts stall cycles of one memory access; flags the last allowed one.
// Rev    : 1.0  initial release
// ============================================================================
module mano_mem_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam logic [7:0] C_LIMIT = 8'(WAIT_MAX - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 8'd0;
        end else if (enable) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && !clear && (count_q == C_LIMIT);

endmodule
`default_nettype wire

// File: rtl/mano_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module : mano_control_sequencer
// Brief  : T0..T6 fetch/decode/execute sequencer emitting the datapath control word.
// Rev    : 1.0  initial release
// ============================================================================
module mano_control_sequencer
    import mano_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  opcode,
    input  logic        ind_bit,
    input  logic [11:0] ir_low,
    input  logic        ac_zero,
    input  logic        ac_neg,
    input  logic        dr_zero,
    input  logic        mem_ready,
    output logic [16:0] ctrl_word,
    output logic [2:0]  sc_out,
    output logic        busy,
    output logic        halted,
    output logic        bus_err
);

    state_t          state_q, state_d;
    logic [2:0]      d_q, d_d;
    logic            i_q, i_d;
    logic            bus_err_q, bus_err_d;
    logic [CW_W-1:0] word_q, word_d;

    logic w_in_mem;
    logic w_advance;
    logic w_timeout;
    logic w_halt_req;
    logic w_unused_ir_bits;

    function automatic logic [CW_W-1:0] word_for(
        input state_t      s,
        input logic [2:0]  d,
        input logic        i,
        input logic [11:0] irl,
        input logic        acz,
        input logic        acn
    );
        logic [2:0]  bus;
        logic [2:0]  alu;
        logic [10:0] st;
        bus = BUS_NONE;
        alu = ALU_NONE;
        st  = '0;
        case (s)
            S_T0: begin
                bus = BUS_PC;  st[CW_LD_AR] = 1'b1;
            end
            S_T1: begin
                bus = BUS_MEM; st[CW_INC_PC] = 1'b1; st[CW_LD_IR] = 1'b1; st[CW_MEM_RD] = 1'b1;
            end
            S_T2: begin
                bus = BUS_IR;  st[CW_LD_AR] = 1'b1; st[CW_LD_I] = 1'b1;
            end
            S_T3: begin
                if (d == OP_REG && !i) begin
                    if (irl[11])     begin alu = ALU_CLA; st[CW_LD_AC] = 1'b1; end
                    else if (irl[9]) begin alu = ALU_CMA; st[CW_LD_AC] = 1'b1; end
                    else if (irl[5]) begin alu = ALU_INC; st[CW_LD_AC] = 1'b1; end
                    else if (irl[4]) st[CW_INC_PC] = !acn && !acz;
                    else if (irl[3]) st[CW_INC_PC] = acn;
                    else if (irl[2]) st[CW_INC_PC] = acz;
                end else if (d != OP_REG && i) begin
                    bus = BUS_MEM; st[CW_MEM_RD] = 1'b1; st[CW_LD_AR] = 1'b1;
                end
            end
            S_T4: begin
                case (d)
                    OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
                        bus = BUS_MEM; st[CW_MEM_RD] = 1'b1; st[CW_LD_DR] = 1'b1;
                    end
                    OP_STA: begin bus = BUS_AC; st[CW_MEM_WR] = 1'b1; end
                    OP_BUN: begin bus = BUS_AR; st[CW_LD_PC] = 1'b1; end
                    OP_BSA: begin
                        bus = BUS_PC; st[CW_MEM_WR] = 1'b1; st[CW_INC_AR] = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (d)
                    OP_AND:  begin alu = ALU_AND;   st[CW_LD_AC] = 1'b1; end
                    OP_ADD:  begin alu = ALU_ADD;   st[CW_LD_AC] = 1'b1; end
                    OP_LDA:  begin alu = ALU_LD_DR; st[CW_LD_AC] = 1'b1; end
                    OP_BSA:  begin bus = BUS_AR;    st[CW_LD_PC] = 1'b1; end
                    OP_ISZ:  st[CW_INC_DR] = 1'b1;
                    default: ;
                endcase
            end
            S_T6: begin
                bus = BUS_DR; st[CW_MEM_WR] = 1'b1;
            end
            default: ;
        endcase
        return {bus, alu, st};
    endfunction

    // HLT only wins when no higher-priority register-reference bit is set
    assign w_halt_req = ir_low[0] && !(ir_low[11] || ir_low[9] || ir_low[5] ||
                                       ir_low[4]  || ir_low[3] || ir_low[2]);
    assign w_unused_ir_bits = ^{ir_low[10], ir_low[8:6], ir_low[1]};

    assign w_in_mem  = word_q[CW_MEM_RD] || word_q[CW_MEM_WR];
    assign w_advance = !w_in_mem || mem_ready;

    mano_mem_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_advance),
        .enable  (!w_advance),
        .expired (w_timeout)
    );

    always_comb begin
        state_d   = state_q;
        d_d       = d_q;
        i_d       = i_q;
        bus_err_d = bus_err_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d   = S_T0;
                    bus_err_d = 1'b0;
                end
            end
            S_T0: state_d = S_T1;
            S_T1: if (w_advance) state_d = S_T2;
            S_T2: begin
                state_d = S_T3;
                d_d     = opcode;
                i_d     = ind_bit;
            end
            S_T3: begin
                if (w_advance) begin
                    if (d_q == OP_REG) begin
                        state_d = (!i_q && w_halt_req) ? S_HALT : S_T0;
                    end else begin
                        state_d = S_T4;
                    end
                end
            end
            S_T4: begin
                if (w_advance) begin
                    state_d = (d_q inside {OP_AND, OP_ADD, OP_LDA, OP_BSA, OP_ISZ}) ? S_T5 : S_T0;
                end
            end
            S_T5: state_d = (d_q == OP_ISZ) ? S_T6 : S_T0;
            S_T6: if (w_advance) state_d = S_T0;
            default: state_d = S_IDLE;
        endcase
        if (w_timeout) begin
            state_d   = S_HALT;
            bus_err_d = 1'b1;
        end
        word_d = word_for(state_d, d_d, i_d, ir_low, ac_zero, ac_neg);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            d_q       <= 3'd0;
            i_q       <= 1'b0;
            bus_err_q <= 1'b0;
            word_q    <= '0;
        end else begin
            state_q   <= state_d;
            d_q       <= d_d;
            i_q       <= i_d;
            bus_err_q <= bus_err_d;
            word_q    <= word_d;
        end
    end

    // Strobes wait for mem_ready; the ISZ skip needs DR as incremented in T5
    always_comb begin
        ctrl_word = word_q;
        if (!w_advance) begin
            ctrl_word = word_q & ~CW_STROBE_MASK;
        end
        if (state_q == S_T6 && dr_zero && mem_ready) begin
            ctrl_word[CW_INC_PC] = 1'b1;
        end
    end

    assign sc_out  = sc_of(state_q);
    assign busy    = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted  = (state_q == S_HALT);
    assign bus_err = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mano_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_mano_control_sequencer
// Brief  : Directed self-checking bench for the Mano control sequencer.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mano_control_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, ind_bit, ac_zero, ac_neg, dr_zero, mem_ready;
    logic [2:0]  opcode;
    logic [11:0] ir_low;
    logic [16:0] ctrl_word;
    logic [2:0]  sc_out;
    logic        busy, halted, bus_err;

    int checks   = 0;
    int failures = 0;

    mano_control_sequencer #(.WAIT_MAX(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .opcode    (opcode),
        .ind_bit   (ind_bit),
        .ir_low    (ir_low),
        .ac_zero   (ac_zero),
        .ac_neg    (ac_neg),
        .dr_zero   (dr_zero),
        .mem_ready (mem_ready),
        .ctrl_word (ctrl_word),
        .sc_out    (sc_out),
        .busy      (busy),
        .halted    (halted),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    localparam logic [10:0] LD_AR  = 11'h400;
    localparam logic [10:0] LD_PC  = 11'h200;
    localparam logic [10:0] INC_PC = 11'h100;
    localparam logic [10:0] LD_IR  = 11'h080;
    localparam logic [10:0] LD_DR  = 11'h040;
    localparam logic [10:0] INC_DR = 11'h020;
    localparam logic [10:0] INC_AR = 11'h010;
    localparam logic [10:0] LD_AC  = 11'h008;
    localparam logic [10:0] MEM_RD = 11'h004;
    localparam logic [10:0] MEM_WR = 11'h002;
    localparam logic [10:0] LD_I   = 11'h001;

    function automatic logic [16:0] cw(input logic [2:0] b, input logic [2:0] a,
                                       input logic [10:0] s);
        return {b, a, s};
    endfunction

    typedef struct {
        logic [11:0] irl;
        logic        i;
        logic        acz;
        logic        acn;
        logic [16:0] w;
    } rr_t;

    rr_t rr [11];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cyc(input string tag, input logic [16:0] w, input logic [2:0] sc);
        #1;
        check_eq({tag, "_cw"},   32'(ctrl_word), 32'(w));
        check_eq({tag, "_sc"},   32'(sc_out),    32'(sc));
        check_eq({tag, "_busy"}, 32'(busy),      32'd1);
    endtask

    task automatic expect_idle(input string tag, input logic h, input logic e);
        #1;
        check_eq({tag, "_cw"},     32'(ctrl_word), 32'd0);
        check_eq({tag, "_sc"},     32'(sc_out),    32'd0);
        check_eq({tag, "_busy"},   32'(busy),      32'd0);
        check_eq({tag, "_halted"}, 32'(halted),    32'(h));
        check_eq({tag, "_buserr"}, 32'(bus_err),   32'(e));
    endtask

    // From an observed T0: step through T1, T2 and into T3
    task automatic fetch(input string tag);
        tick(); expect_cyc({tag, "_t1"}, cw(3'd7, 3'd0, INC_PC | LD_IR | MEM_RD), 3'd1);
        tick(); expect_cyc({tag, "_t2"}, cw(3'd5, 3'd0, LD_AR | LD_I), 3'd2);
        tick();
    endtask

    initial begin
        rr[0]  = '{12'h010, 1'b0, 1'b0, 1'b0, cw(3'd0, 3'd0, INC_PC)};
        rr[1]  = '{12'h010, 1'b0, 1'b1, 1'b0, 17'h0};
        rr[2]  = '{12'h008, 1'b0, 1'b0, 1'b1, cw(3'd0, 3'd0, INC_PC)};
        rr[3]  = '{12'h004, 1'b0, 1'b0, 1'b0, 17'h0};
        rr[4]  = '{12'h004, 1'b0, 1'b1, 1'b0, cw(3'd0, 3'd0, INC_PC)};
        rr[5]  = '{12'h800, 1'b0, 1'b0, 1'b0, cw(3'd0, 3'd6, LD_AC)};
        rr[6]  = '{12'h200, 1'b0, 1'b0, 1'b0, cw(3'd0, 3'd4, LD_AC)};
        rr[7]  = '{12'h020, 1'b0, 1'b0, 1'b0, cw(3'd0, 3'd5, LD_AC)};
        rr[8]  = '{12'h821, 1'b0, 1'b0, 1'b0, cw(3'd0, 3'd6, LD_AC)};
        rr[9]  = '{12'h040, 1'b0, 1'b0, 1'b0, 17'h0};
        rr[10] = '{12'h800, 1'b1, 1'b0, 1'b0, 17'h0};

        reset = 1'b1; start = 1'b0; opcode = 3'd0; ind_bit = 1'b0; ir_low = 12'h0;
        ac_zero = 1'b0; ac_neg = 1'b0; dr_zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        expect_idle("reset", 1'b0, 1'b0);
        reset = 1'b0;
        tick(); expect_idle("idle_hold", 1'b0, 1'b0);

        // ADD direct; opcode changed in T4 must not affect T5
        opcode = 3'd1; ind_bit = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        expect_cyc("add_t0", cw(3'd2, 3'd0, LD_AR), 3'd0);
        fetch("add");
        expect_cyc("add_t3", 17'h0, 3'd3);
        tick(); expect_cyc("add_t4", cw(3'd7, 3'd0, LD_DR | MEM_RD), 3'd4);
        opcode = 3'd3;
        tick(); expect_cyc("add_t5", cw(3'd0, 3'd2, LD_AC), 3'd5);
        tick(); expect_cyc("add_end", cw(3'd2, 3'd0, LD_AR), 3'd0);

        // LDA indirect with three stall cycles in T3
        opcode = 3'd2; ind_bit = 1'b1;
        fetch("lda");
        mem_ready = 1'b0;
        expect_cyc("lda_s0", cw(3'd7, 3'd0, MEM_RD), 3'd3);
        tick(); expect_cyc("lda_s1", cw(3'd7, 3'd0, MEM_RD), 3'd3);
        tick(); expect_cyc("lda_s2", cw(3'd7, 3'd0, MEM_RD), 3'd3);
        tick(); mem_ready = 1'b1;
        expect_cyc("lda_t3", cw(3'd7, 3'd0, LD_AR | MEM_RD), 3'd3);
        tick(); expect_cyc("lda_t4", cw(3'd7, 3'd0, LD_DR | MEM_RD), 3'd4);
        tick(); expect_cyc("lda_t5", cw(3'd0, 3'd3, LD_AC), 3'd5);
        tick(); expect_cyc("lda_end", cw(3'd2, 3'd0, LD_AR), 3'd0);

        // ISZ with dr_zero=1 then dr_zero=0
        for (int k = 0; k < 2; k++) begin
            opcode = 3'd6; ind_bit = 1'b0;
            fetch("isz");
            expect_cyc("isz_t3", 17'h0, 3'd3);
            tick(); expect_cyc("isz_t4", cw(3'd7, 3'd0, LD_DR | MEM_RD), 3'd4);
            tick(); expect_cyc("isz_t5", cw(3'd0, 3'd0, INC_DR), 3'd5);
            tick(); dr_zero = (k == 0);
            expect_cyc(k == 0 ? "isz_t6_skip" : "isz_t6_noskip",
                       (k == 0) ? cw(3'd3, 3'd0, MEM_WR | INC_PC) : cw(3'd3, 3'd0, MEM_WR), 3'd6);
            tick(); dr_zero = 1'b0;
            expect_cyc("isz_end", cw(3'd2, 3'd0, LD_AR), 3'd0);
        end

        // BSA; a start pulse while busy must be ignored
        opcode = 3'd5;
        fetch("bsa");
        expect_cyc("bsa_t3", 17'h0, 3'd3);
        tick(); expect_cyc("bsa_t4", cw(3'd2, 3'd0, MEM_WR | INC_AR), 3'd4);
        start = 1'b1;
        tick(); start = 1'b0;
        expect_cyc("bsa_t5", cw(3'd1, 3'd0, LD_PC), 3'd5);
        tick(); expect_cyc("bsa_end", cw(3'd2, 3'd0, LD_AR), 3'd0);

        opcode = 3'd3;
        fetch("sta");
        tick(); expect_cyc("sta_t4", cw(3'd4, 3'd0, MEM_WR), 3'd4);
        tick(); expect_cyc("sta_end", cw(3'd2, 3'd0, LD_AR), 3'd0);

        opcode = 3'd4;
        fetch("bun");
        tick(); expect_cyc("bun_t4", cw(3'd1, 3'd0, LD_PC), 3'd4);
        tick(); expect_cyc("bun_end", cw(3'd2, 3'd0, LD_AR), 3'd0);

        // Register-reference and I/O table
        for (int n = 0; n < 11; n++) begin
            opcode = 3'd7; ind_bit = rr[n].i; ir_low = rr[n].irl;
            ac_zero = rr[n].acz; ac_neg = rr[n].acn;
            fetch("rr");
            expect_cyc($sformatf("rr%0d_t3", n), rr[n].w, 3'd3);
            tick(); expect_cyc($sformatf("rr%0d_end", n), cw(3'd2, 3'd0, LD_AR), 3'd0);
        end
        ac_zero = 1'b0; ac_neg = 1'b0; ind_bit = 1'b0;

        // HLT, then restart
        ir_low = 12'h001;
        fetch("hlt");
        expect_cyc("hlt_t3", 17'h0, 3'd3);
        tick(); expect_idle("hlt", 1'b1, 1'b0);
        tick(); expect_idle("hlt_hold", 1'b1, 1'b0);
        ir_low = 12'h000; start = 1'b1;
        tick(); start = 1'b0;
        expect_cyc("restart_t0", cw(3'd2, 3'd0, LD_AR), 3'd0);

        // Memory timeout in T1 (WAIT_MAX = 4)
        opcode = 3'd1;
        tick(); mem_ready = 1'b0;
        expect_cyc("to_c0", cw(3'd7, 3'd0, MEM_RD), 3'd1);
        for (int c = 1; c < 4; c++) begin
            tick(); expect_cyc($sformatf("to_c%0d", c), cw(3'd7, 3'd0, MEM_RD), 3'd1);
        end
        tick(); expect_idle("to_halt", 1'b1, 1'b1);
        mem_ready = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        expect_cyc("to_restart_t0", cw(3'd2, 3'd0, LD_AR), 3'd0);
        check_eq("to_restart_buserr", 32'(bus_err), 32'd0);

        // Asynchronous reset in the middle of T4
        fetch("rst");
        expect_cyc("rst_t3", 17'h0, 3'd3);
        tick(); expect_cyc("rst_t4", cw(3'd7, 3'd0, LD_DR | MEM_RD), 3'd4);
        reset = 1'b1;
        expect_idle("rst_async", 1'b0, 1'b0);
        tick(); reset = 1'b0;
        tick(); expect_idle("rst_after", 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
